// File: rtl/mem_request_ctrl_pkg.sv
// Shared types for the data-request controller.
// The controller state encoding and the default watchdog width live here.
package mem_request_ctrl_pkg;

    localparam int WORD_W    = 32;
    localparam int TMO_W_DEF = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DREQ,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/mem_request_ctrl_sat_counter.sv
// Up-counter with synchronous clear.
// The SAT parameter selects between saturating at all-ones and wrapping.
module sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (!(SAT && (&cnt_q))) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_request_ctrl.sv
// Data-request controller between the pipeline and the I/D caches.
// Holds data enables, address and store data stable until dhit.
module mem_request_ctrl
    import mem_request_ctrl_pkg::*;
#(
    parameter int ADDR_W = $bits(word_t),
    parameter int DATA_W = $bits(word_t),
    parameter int TMO_W  = TMO_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic [DATA_W-1:0] dstore_in,
    input  logic              halt,
    output logic              imemren,
    output logic              dmemren,
    output logic              dmemwen,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic              proto_err,
    output logic [CNT_W-1:0]  dreq_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [TMO_W-1:0] WD_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e            state_q;
    logic              ren_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              tmo_q;
    logic              perr_q;
    logic              hpend_q;

    logic              in_dreq;
    logic              capture;
    logic              done;
    logic              wd_inc;
    logic              wd_clr;
    logic [TMO_W-1:0]  wd_cnt;

    assign in_dreq = (state_q == ST_DREQ);
    assign capture = (state_q == ST_IDLE) && ihit && (memread || memwrite);
    assign done    = in_dreq && dhit;
    assign wd_inc  = in_dreq && !dhit;
    assign wd_clr  = done || capture;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            tmo_q   <= 1'b0;
            perr_q  <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dhit) begin
                        perr_q <= 1'b1;
                    end
                    if (capture) begin
                        // Conflicting load+store: the store wins.
                        ren_q   <= memread && !memwrite;
                        wen_q   <= memwrite;
                        addr_q  <= daddr_in;
                        store_q <= dstore_in;
                        hpend_q <= halt;
                        state_q <= ST_DREQ;
                        if (memread && memwrite) begin
                            perr_q <= 1'b1;
                        end
                    end else if (halt) begin
                        state_q <= ST_HALTED;
                    end
                end
                ST_DREQ: begin
                    if (dhit) begin
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        hpend_q <= 1'b0;
                        state_q <= (hpend_q || halt) ? ST_HALTED : ST_IDLE;
                    end else begin
                        if (halt) begin
                            hpend_q <= 1'b1;
                        end
                        if (wd_cnt == WD_PRE) begin
                            tmo_q <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    ren_q <= 1'b0;
                    wen_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(TMO_W), .SAT(1'b1)) u_wd (
        .clk   (clk),
        .nrst  (nrst),
        .inc_i (wd_inc),
        .clr_i (wd_clr),
        .cnt_o (wd_cnt)
    );

    sat_counter #(.W(CNT_W), .SAT(1'b0)) u_dreq (
        .clk   (clk),
        .nrst  (nrst),
        .inc_i (done),
        .clr_i (1'b0),
        .cnt_o (dreq_cnt)
    );

    sat_counter #(.W(CNT_W), .SAT(1'b1)) u_stall (
        .clk   (clk),
        .nrst  (nrst),
        .inc_i (in_dreq),
        .clr_i (1'b0),
        .cnt_o (stall_cnt)
    );

    assign imemren     = nrst && (state_q != ST_HALTED);
    assign dmemren     = ren_q;
    assign dmemwen     = wen_q;
    assign dmemaddr    = addr_q;
    assign dmemstore   = store_q;
    assign busy        = in_dreq;
    assign halted      = (state_q == ST_HALTED);
    assign timeout_err = tmo_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed bench for mem_request_ctrl (TMO_W=3, watchdog limit 7).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mem_request_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic          ihit, dhit, memread, memwrite, halt;
    logic [AW-1:0] daddr_in;
    logic [DW-1:0] dstore_in;
    logic          imemren, dmemren, dmemwen, busy, halted;
    logic          timeout_err, proto_err;
    logic [AW-1:0] dmemaddr;
    logic [DW-1:0] dmemstore;
    logic [CW-1:0] dreq_cnt, stall_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_request_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .TMO_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .nrst(nrst), .ihit(ihit), .dhit(dhit),
        .memread(memread), .memwrite(memwrite),
        .daddr_in(daddr_in), .dstore_in(dstore_in), .halt(halt),
        .imemren(imemren), .dmemren(dmemren), .dmemwen(dmemwen),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .busy(busy),
        .halted(halted), .timeout_err(timeout_err),
        .proto_err(proto_err), .dreq_cnt(dreq_cnt),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        ihit = 0; dhit = 0; memread = 0; memwrite = 0; halt = 0;
    endtask

    task automatic do_reset();
        idle_in();
        nrst = 0;
        step(2);
        nrst = 1;
        step(1);
    endtask

    task automatic cap_load(input logic [AW-1:0] a);
        ihit = 1; memread = 1; daddr_in = a;
        step(1);
        ihit = 0; memread = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_sim: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        daddr_in = '0; dstore_in = '0;
        idle_in();
        nrst = 0;
        step(2);
        chk("rst_imemren", imemren, 0);
        chk("rst_dmemren", dmemren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dreq_cnt", dreq_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        nrst = 1;
        step(1);
        chk("rel_imemren", imemren, 1);

        // Load: 3 waiting cycles, then dhit
        cap_load(32'h40);
        chk("ld_dmemren", dmemren, 1);
        chk("ld_addr", dmemaddr, 32'h40);
        chk("ld_busy", busy, 1);
        step(3);
        dhit = 1;
        step(1);
        dhit = 0;
        chk("ld_done_ren", dmemren, 0);
        chk("ld_done_busy", busy, 0);
        chk("ld_dreq_cnt", dreq_cnt, 1);
        chk("ld_stall_cnt", stall_cnt, 4);

        // Store held while inputs change
        ihit = 1; memwrite = 1; daddr_in = 32'h80;
        dstore_in = 32'hDEADBEEF;
        step(1);
        memwrite = 0; memread = 1;
        daddr_in = 32'h99; dstore_in = 32'h12345678;
        step(2);
        chk("st_store", dmemstore, 32'hDEADBEEF);
        chk("st_addr", dmemaddr, 32'h80);
        chk("st_wen", dmemwen, 1);
        chk("st_ren", dmemren, 0);
        idle_in();
        dhit = 1;
        step(1);
        dhit = 0;
        chk("st_done_wen", dmemwen, 0);
        chk("st_dreq_cnt", dreq_cnt, 2);
        chk("st_stall_cnt", stall_cnt, 7);
        chk("st_perr", proto_err, 0);

        // Halt during a request
        cap_load(32'h10);
        halt = 1;
        step(1);
        halt = 0;
        step(1);
        chk("hd_still_busy", busy, 1);
        dhit = 1;
        step(1);
        dhit = 0;
        chk("hd_halted", halted, 1);
        chk("hd_imemren", imemren, 0);
        chk("hd_dmemren", dmemren, 0);
        chk("hd_dreq_cnt", dreq_cnt, 3);
        chk("hd_stall_cnt", stall_cnt, 10);
        ihit = 1; memread = 1; dhit = 1; halt = 1;
        step(2);
        idle_in();
        chk("hd_ign_halted", halted, 1);
        chk("hd_ign_ren", dmemren, 0);
        chk("hd_ign_perr", proto_err, 0);
        chk("hd_ign_dreq", dreq_cnt, 3);

        // Halt in IDLE with no mem op
        do_reset();
        halt = 1;
        step(1);
        halt = 0;
        chk("hi_halted", halted, 1);
        chk("hi_imemren", imemren, 0);

        // Watchdog: 7 waiting cycles
        do_reset();
        cap_load(32'h20);
        step(6);
        chk("wd_not_yet", timeout_err, 0);
        step(1);
        chk("wd_tmo", timeout_err, 1);
        chk("wd_ren", dmemren, 1);
        dhit = 1;
        step(1);
        dhit = 0;
        chk("wd_done_busy", busy, 0);
        chk("wd_sticky", timeout_err, 1);
        chk("wd_stall", stall_cnt, 8);

        // dhit exactly at the watchdog limit: completion wins
        do_reset();
        cap_load(32'h24);
        step(6);
        dhit = 1;
        step(1);
        dhit = 0;
        chk("wdl_tmo", timeout_err, 0);
        chk("wdl_dreq", dreq_cnt, 1);

        // Protocol errors
        do_reset();
        ihit = 1; memread = 1; memwrite = 1;
        step(1);
        idle_in();
        chk("pe_wen", dmemwen, 1);
        chk("pe_ren", dmemren, 0);
        chk("pe_perr", proto_err, 1);
        do_reset();
        chk("pe_rst_perr", proto_err, 0);
        dhit = 1;
        step(1);
        dhit = 0;
        chk("pe_spur_perr", proto_err, 1);
        chk("pe_spur_busy", busy, 0);
        chk("pe_spur_dreq", dreq_cnt, 0);

        // Async reset mid-request
        do_reset();
        cap_load(32'h30);
        step(2);
        #2;
        nrst = 0;
        #1;
        chk("ar_ren", dmemren, 0);
        chk("ar_busy", busy, 0);
        chk("ar_stall", stall_cnt, 0);
        chk("ar_imemren", imemren, 0);
        step(1);
        nrst = 1;
        step(1);
        chk("ar_rel_imemren", imemren, 1);
        chk("ar_rel_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
